// File: rtl/day10_pkg.sv
// Shared day10 types and sizing.
//   DAY10_MAX_MACHINES : default machine count ceiling per run
//   DAY10_IDX_W        : width able to hold 0..DAY10_MAX_MACHINES
//   machine_idx_t      : machine index/count, shared with the solver lanes
package day10_pkg;
  localparam int DAY10_MAX_MACHINES = 256;
  localparam int DAY10_IDX_W        = $clog2(DAY10_MAX_MACHINES + 1);

  typedef logic [DAY10_IDX_W-1:0] machine_idx_t;

  // Select width for n lanes; a single lane still needs a 1-bit select.
  function automatic int lane_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/day10_writer_scheduler_if.sv
// Lane/writer handshake bundle around the writer scheduler.
//   lane_done, lane_machine_idx : lanes -> scheduler, finished result + its machine index
//   lane_ack                    : scheduler -> lanes, one-hot "your result is written"
//   sel                         : scheduler -> external mux, lane routed to the writer
//   writer_start/last_write     : scheduler -> writer
//   writer_ready                : writer -> scheduler, write finished pulse
// master = scheduler side, slave = lanes/writer side.
interface day10_writer_scheduler_if
  import day10_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = DAY10_IDX_W,
  parameter int LANE_W    = lane_w(NUM_LANES)
);
  logic [NUM_LANES-1:0]            lane_done;
  logic [NUM_LANES-1:0][IDX_W-1:0] lane_machine_idx;
  logic [NUM_LANES-1:0]            lane_ack;
  logic [LANE_W-1:0]               sel;
  logic                            writer_start;
  logic                            writer_last_write;
  logic                            writer_ready;

  modport master (
    input  lane_done, lane_machine_idx, writer_ready,
    output lane_ack, sel, writer_start, writer_last_write
  );

  modport slave (
    output lane_done, lane_machine_idx, writer_ready,
    input  lane_ack, sel, writer_start, writer_last_write
  );
endinterface

// File: rtl/day10_lane_select.sv
// Combinational lane picker: finds the lanes holding the result for next_idx
// and returns the lowest-numbered one.
//   lane_done        : per-lane result-valid
//   lane_machine_idx : per-lane machine index
//   next_idx         : machine index wanted next
//   found            : at least one lane matches
//   lane             : lowest matching lane (0 when none)
module day10_lane_select
  import day10_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = DAY10_IDX_W,
  parameter int LANE_W    = lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0]            lane_done,
  input  logic [NUM_LANES-1:0][IDX_W-1:0] lane_machine_idx,
  input  logic [IDX_W-1:0]                next_idx,
  output logic                            found,
  output logic [LANE_W-1:0]               lane
);
  logic [NUM_LANES-1:0] match;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_match
    // Full-width compare so index MAX-1 never aliases a wrapped value.
    assign match[i] = lane_done[i] && (lane_machine_idx[i] == next_idx);
  end

  // Walk high to low so the lowest matching lane is the last writer.
  always_comb begin
    found = |match;
    lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (match[i]) lane = LANE_W'(i);
    end
  end
endmodule

// File: rtl/day10_writer_scheduler.sv
// Shares the single day10 output writer between NUM_LANES solver lanes and
// emits results strictly in machine-index order.
//   clk, rst_n      : clock, synchronous active-low reset
//   run_start       : begin a run (honoured in IDLE only)
//   total_machines  : machines in the run, latched on an accepted run_start
//   bus (master)    : lane done/idx/ack, writer sel/start/last_write/ready
//   busy            : not IDLE
//   run_done        : 1-cycle pulse when the run is complete
module day10_writer_scheduler
  import day10_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int MAX_MACHINES = DAY10_MAX_MACHINES,
  parameter int LANE_W       = (NUM_LANES <= 1) ? 1 : $clog2(NUM_LANES),
  parameter int IDX_W        = $clog2(MAX_MACHINES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run_start,
  input  logic [IDX_W-1:0]        total_machines,
  day10_writer_scheduler_if.master bus,
  output logic                    busy,
  output logic                    run_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_START, S_WAIT, S_ACK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  next_idx_q, next_idx_d;
  logic [IDX_W-1:0]  total_q, total_d;
  logic [LANE_W-1:0] sel_q, sel_d;
  logic              last_q, last_d;

  logic              found;
  logic [LANE_W-1:0] found_lane;

  day10_lane_select #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W),
    .LANE_W    (LANE_W)
  ) u_lane_select (
    .lane_done        (bus.lane_done),
    .lane_machine_idx (bus.lane_machine_idx),
    .next_idx         (next_idx_q),
    .found            (found),
    .lane             (found_lane)
  );

  always_comb begin
    state_d    = state_q;
    next_idx_d = next_idx_q;
    total_d    = total_q;
    sel_d      = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_start) begin
          if (total_machines != '0) begin
            total_d    = total_machines;
            next_idx_d = '0;
            state_d    = S_SEARCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEARCH: begin
        if (found) begin
          sel_d   = found_lane;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (bus.writer_ready) state_d = S_ACK;
      S_ACK: begin
        if (next_idx_q == total_q - IDX_W'(1)) begin
          state_d = S_DONE;
        end else begin
          next_idx_d = next_idx_q + IDX_W'(1);
          state_d    = S_SEARCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Computed from next-state values so the registered flag lines up
    // with the START/WAIT cycles it describes.
    last_d = ((state_d == S_START) || (state_d == S_WAIT)) &&
             (next_idx_d == total_d - IDX_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      next_idx_q <= '0;
      total_q    <= '0;
      sel_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_idx_q <= next_idx_d;
      total_q    <= total_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
    end
  end

  // Pulses decode straight from the state register; sel_q only changes on
  // leaving SEARCH, so it holds from START through ACK.
  assign bus.writer_start      = (state_q == S_START);
  assign bus.writer_last_write = last_q;
  assign bus.sel               = sel_q;
  assign bus.lane_ack          = (state_q == S_ACK) ? (NUM_LANES'(1) << sel_q) : '0;
  assign busy                  = (state_q != S_IDLE);
  assign run_done              = (state_q == S_DONE);
endmodule

// File: tb/tb_day10_writer_scheduler.sv
// Self-checking bench for day10_writer_scheduler (NUM_LANES=4, MAX=256).
// The reference model is a picture of the protocol: writes must appear in
// machine order 0..total-1, each from the lowest lane currently holding that
// index, with ack one cycle after writer_ready and run_done one cycle after
// the final ack.
module tb_day10_writer_scheduler;
  localparam int NL = 4;
  localparam int IW = 9;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_start;
  logic [IW-1:0] total_machines;
  logic          busy, run_done;

  day10_writer_scheduler_if #(.NUM_LANES(NL), .IDX_W(IW), .LANE_W(LW)) bus ();

  day10_writer_scheduler #(.NUM_LANES(NL), .MAX_MACHINES(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_start      (run_start),
    .total_machines (total_machines),
    .bus            (bus),
    .busy           (busy),
    .run_done       (run_done)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  // lane model
  bit [NL-1:0] m_done;
  int m_idx[NL];
  int m_cnt[NL];
  bit auto_lanes;
  int next_assign;
  // run / writer model
  int run_total, writes, starts, wr_cnt, cur_lane, fixed_delay, cyc;
  int start_cyc, ack_cyc;
  bit in_run, wr_out, cur_last, ack_due, done_due, done_seen;
  bit [NL-1:0] ack_mask;
  int sel_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NL; i++) begin
      bus.lane_done[i]        = m_done[i];
      bus.lane_machine_idx[i] = IW'(m_idx[i]);
    end
  endtask

  function automatic int lowest_holder(input int idx);
    for (int i = 0; i < NL; i++)
      if (m_done[i] && m_idx[i] == idx) return i;
    return -1;
  endfunction

  // One clock: sample #1 after the edge, check, update model, drive next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    run_start    = 1'b0;
    bus.writer_ready = 1'b0;
    chk("busy", busy, in_run);
    chk("run_done", run_done, done_due);
    if (run_done) begin done_seen = 1; in_run = 0; end
    done_due = 0;
    chk("lane_ack", bus.lane_ack, ack_due ? (NL'(1) << cur_lane) : '0);
    ack_mask |= bus.lane_ack;
    if (ack_due) begin
      m_done[cur_lane] = 0;
      writes++;
      wr_out  = 0;
      ack_cyc = cyc;
      if (writes == run_total) done_due = 1;
    end
    ack_due = 0;
    if (bus.writer_start) begin
      chk("start_legal", {wr_out, in_run && writes < run_total}, 2'b01);
      chk("sel", bus.sel, lowest_holder(writes));
      chk("last_write", bus.writer_last_write, writes == run_total - 1);
      sel_q.push_back(int'(bus.sel));
      starts++;
      start_cyc = cyc;
      wr_out    = 1;
      cur_lane  = int'(bus.sel);
      cur_last  = (writes == run_total - 1);
      wr_cnt    = 1 + ((fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4)));
    end else begin
      chk("last_write_hold", bus.writer_last_write, wr_out ? cur_last : 1'b0);
      if (wr_out) chk("sel_stable", bus.sel, cur_lane);
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin bus.writer_ready = 1'b1; ack_due = 1; end
      end
    end
    if (auto_lanes) begin
      for (int i = 0; i < NL; i++) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) m_done[i] = 1;
        end else if (!m_done[i] && next_assign < run_total) begin
          m_idx[i] = next_assign++;
          m_cnt[i] = int'($urandom_range(1, 8));
        end
      end
    end
    drive_lanes();
  endtask

  task automatic start_run(input int total);
    run_total      = total;
    writes         = 0;
    starts         = 0;
    next_assign    = 0;
    ack_mask       = '0;
    done_seen      = 0;
    sel_q.delete();
    total_machines = IW'(total);
    run_start      = 1'b1;
    in_run         = 1;
    if (total == 0) done_due = 1;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && !done_seen; n++) step();
    chk("run_done_timeout", done_seen, 1'b1);
    if (!done_seen) in_run = 0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_done = '0;
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    drive_lanes();
    in_run = 0; run_total = 0; wr_out = 0; wr_cnt = 0;
    ack_due = 0; done_due = 0;
    step();
    chk("reset_sel", bus.sel, 0);
    chk("reset_start", bus.writer_start, 0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; run_start = 1'b0; total_machines = '0;
    bus.writer_ready = 1'b0;
    auto_lanes = 0; fixed_delay = -1; cyc = 0;
    for (int i = 0; i < NL; i++) begin m_idx[i] = 0; m_cnt[i] = 0; end
    m_done = '0;
    drive_lanes();
    do_reset();

    // 1: lanes finish idx 3,1,0,2 -> written in order 0..3 from lanes 2,1,3,0
    start_run(4);
    step();
    m_done[0] = 1; m_idx[0] = 3; drive_lanes(); step();
    m_done[1] = 1; m_idx[1] = 1; drive_lanes(); step();
    m_done[2] = 1; m_idx[2] = 0; drive_lanes(); step();
    m_done[3] = 1; m_idx[3] = 2; drive_lanes();
    wait_done(200);
    chk("t1_writes", writes, 4);
    chk("t1_nsel", sel_q.size(), 4);
    if (sel_q.size() == 4) begin
      chk("t1_sel0", sel_q[0], 2);
      chk("t1_sel1", sel_q[1], 1);
      chk("t1_sel2", sel_q[2], 3);
      chk("t1_sel3", sel_q[3], 0);
    end

    // 2: total=0 -> run_done next cycle, busy for one cycle, no writes
    start_run(0);
    step();
    step();
    chk("t2_starts", starts, 0);
    chk("t2_done", done_seen, 1'b1);

    // 3: total=1, lane2 idx0, ready 5 cycles after start
    fixed_delay = 4;
    start_run(1);
    m_done[2] = 1; m_idx[2] = 0; drive_lanes();
    wait_done(100);
    chk("t3_starts", starts, 1);
    chk("t3_ack_mask", ack_mask, 4'b0100);
    chk("t3_ack_latency", ack_cyc - start_cyc, 6);
    fixed_delay = -1;

    // 4: lanes 1 and 3 both idx0 -> lane1 wins, lane3 never acked
    start_run(2);
    m_done[1] = 1; m_idx[1] = 0;
    m_done[3] = 1; m_idx[3] = 0; drive_lanes();
    for (int n = 0; n < 100 && writes < 1; n++) step();
    chk("t4_first_write", writes, 1);
    repeat (10) step();
    chk("t4_stalled", starts, 1);
    m_done[0] = 1; m_idx[0] = 1; drive_lanes();
    wait_done(100);
    chk("t4_ack_mask", ack_mask, 4'b0011);
    m_done = '0; drive_lanes(); step();

    // 5: reset while waiting on the writer, then a clean run
    fixed_delay = 30;
    start_run(2);
    m_done[0] = 1; m_idx[0] = 0; drive_lanes();
    for (int n = 0; n < 50 && !wr_out; n++) step();
    chk("t5_started", wr_out, 1'b1);
    step();
    do_reset();
    chk("t5_no_ack", ack_mask, 4'b0000);
    fixed_delay = -1;
    auto_lanes = 1;
    start_run(3);
    wait_done(500);
    chk("t5_writes", writes, 3);
    auto_lanes = 0;

    // 6: run_start and writer_ready while searching are ignored
    start_run(2);
    step();
    run_start = 1'b1; total_machines = '0; bus.writer_ready = 1'b1;
    step();
    step();
    chk("t6_no_start", starts, 0);
    chk("t6_busy", busy, 1'b1);
    auto_lanes = 1;
    wait_done(500);
    chk("t6_writes", writes, 2);
    chk("t6_starts", starts, 2);

    // randomized runs, then a full-size run
    for (int r = 0; r < 6; r++) begin
      start_run(int'($urandom_range(1, 24)));
      wait_done(3000);
      chk("rnd_writes", writes, run_total);
      chk("rnd_starts", starts, run_total);
    end
    start_run(256);
    wait_done(20000);
    chk("max_writes", writes, 256);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
